// File: rtl/ula_multiciclo_if.sv
// Handshake/operand bundle between the multicycle datapath controller
// and the execution unit.
interface ula_multiciclo_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [5:0]       ctrl;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] hi;
  logic             zero;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output start, ctrl, a, b,
    input  result, hi, zero, busy, done, div_by_zero, overflow
  );

  modport slave (
    input  start, ctrl, a, b,
    output result, hi, zero, busy, done, div_by_zero, overflow
  );
endinterface

// File: rtl/ula_multiciclo.sv
// Multicycle ALU: 1-cycle logic/arith ops, WIDTH-step MULU/DIVU.
// Define ULA_OVERFLOW_EN to build signed ADD/SUB overflow detection.
module ula_multiciclo #(
  parameter int WIDTH = 32
) (
  input logic             clk,
  input logic             rst,
  ula_multiciclo_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_AND  = 6'b000001;
  localparam logic [5:0] OP_OR   = 6'b001000;
  localparam logic [5:0] OP_SUB  = 6'b001111;
  localparam logic [5:0] OP_SLT  = 6'b001101;
  localparam logic [5:0] OP_SGT  = 6'b001001;
  localparam logic [5:0] OP_MULU = 6'b011000;
  localparam logic [5:0] OP_DIVU = 6'b011010;

  typedef enum logic [2:0] {
    IDLE,
    EXEC,
    MUL,
    DIV,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [5:0]       ctrl_q, ctrl_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             zero_q, zero_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             slt;
  logic             sgt;

  assign sum  = a_q + b_q;
  assign diff = a_q - b_q;
  assign slt  = $signed(a_q) < $signed(b_q);
  assign sgt  = $signed(a_q) > $signed(b_q);

  // Shift-add: upper half accumulates, lower half shifts out the multiplier.
  logic [WIDTH:0]     msum;
  logic [2*WIDTH-1:0] mul_next;

  assign msum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
              + {1'b0, (acc_q[0] ? a_q : {WIDTH{1'b0}})};
  assign mul_next = {msum, acc_q[WIDTH-1:1]};

  // Restoring divide: upper half is the remainder, lower half the quotient.
  logic [WIDTH:0]     dsh;
  logic [WIDTH:0]     dsub;
  logic               dge;
  logic [WIDTH-1:0]   rem_n;
  logic [2*WIDTH-1:0] div_next;

  assign dsh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign dsub  = dsh - {1'b0, b_q};
  assign dge   = ~dsub[WIDTH];
  assign rem_n = dge ? dsub[WIDTH-1:0] : dsh[WIDTH-1:0];
  assign div_next = {rem_n, acc_q[WIDTH-2:0], dge};

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    ctrl_d   = ctrl_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    result_d = result_q;
    hi_d     = hi_q;
    zero_d   = zero_q;
    dbz_d    = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d    = bus.a;
          b_d    = bus.b;
          ctrl_d = bus.ctrl;
          cnt_d  = CW'(WIDTH - 1);
          last_d = 1'b0;
          if (bus.ctrl == OP_MULU) begin
            acc_d   = {{WIDTH{1'b0}}, bus.b};
            state_d = MUL;
          end else if (bus.ctrl == OP_DIVU && bus.b != '0) begin
            acc_d   = {{WIDTH{1'b0}}, bus.a};
            state_d = DIV;
          end else begin
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        hi_d  = '0;
        dbz_d = 1'b0;
        unique case (ctrl_q)
          OP_AND:  result_d = a_q & b_q;
          OP_OR:   result_d = a_q | b_q;
          OP_SUB:  result_d = diff;
          OP_SLT:  result_d = {{(WIDTH-1){1'b0}}, slt};
          OP_SGT:  result_d = {{(WIDTH-1){1'b0}}, sgt};
          OP_DIVU: begin
            result_d = '1;
            hi_d     = a_q;
            dbz_d    = 1'b1;
          end
          default: result_d = sum;
        endcase
        zero_d  = (result_d == '0);
        state_d = DONE;
      end
      MUL, DIV: begin
        // Extra cycle after the last step copies the accumulator out.
        if (last_q) begin
          result_d = acc_q[WIDTH-1:0];
          hi_d     = acc_q[2*WIDTH-1:WIDTH];
          zero_d   = (acc_q[WIDTH-1:0] == '0);
          dbz_d    = 1'b0;
          state_d  = DONE;
        end else begin
          acc_d = (state_q == MUL) ? mul_next : div_next;
          if (cnt_q == '0) last_d = 1'b1;
          else             cnt_d  = cnt_q - CW'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      ctrl_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      last_q   <= 1'b0;
      result_q <= '0;
      hi_q     <= '0;
      zero_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      ctrl_q   <= ctrl_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      zero_q   <= zero_d;
      dbz_q    <= dbz_d;
    end
  end

  assign bus.result      = result_q;
  assign bus.hi          = hi_q;
  assign bus.zero        = zero_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = (state_q == DONE);

`ifdef ULA_OVERFLOW_EN
  logic ovf_q, ovf_d;
  logic is_add;
  logic add_ovf;
  logic sub_ovf;

  assign is_add  = !(ctrl_q inside {OP_AND, OP_OR, OP_SUB, OP_SLT,
                                    OP_SGT, OP_MULU, OP_DIVU});
  assign add_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1])
                 && (sum[WIDTH-1] != a_q[WIDTH-1]);
  assign sub_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1])
                 && (diff[WIDTH-1] != a_q[WIDTH-1]);

  always_comb begin
    ovf_d = ovf_q;
    if (state_q == EXEC) begin
      ovf_d = (is_add && add_ovf) || (ctrl_q == OP_SUB && sub_ovf);
    end else if ((state_q == MUL || state_q == DIV) && last_q) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign bus.overflow = ovf_q;
`else
  assign bus.overflow = 1'b0;
`endif

endmodule

// File: tb/tb_ula_multiciclo.sv
// Directed-vector bench for ula_multiciclo: op table, latency,
// handshake and reset corner cases.
module tb_ula_multiciclo;

  localparam int W = 32;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_AND  = 6'b000001;
  localparam logic [5:0] OP_OR   = 6'b001000;
  localparam logic [5:0] OP_SUB  = 6'b001111;
  localparam logic [5:0] OP_SLT  = 6'b001101;
  localparam logic [5:0] OP_SGT  = 6'b001001;
  localparam logic [5:0] OP_MULU = 6'b011000;
  localparam logic [5:0] OP_DIVU = 6'b011010;

`ifdef ULA_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic clk;
  logic rst;

  ula_multiciclo_if #(.WIDTH(W)) bif ();

  ula_multiciclo #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [31:0] hi;
    logic        z;
    logic        dbz;
    logic        ovf;
    int          lat;
  } vec_t;

  localparam int NV = 18;
  vec_t vt[NV];

  int n_vec;
  int n_err;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  // Issue one op, optionally poke start mid-flight, wait for done.
  task automatic run_op(input logic [5:0] c, input logic [31:0] a,
                        input logic [31:0] b, input bit poke,
                        output int lat, output int bcnt);
    bit got_done;
    got_done = 1'b0;
    @(negedge clk);
    bif.start = 1'b1;
    bif.ctrl  = c;
    bif.a     = a;
    bif.b     = b;
    @(posedge clk);
    #1;
    bif.start = 1'b0;
    bif.ctrl  = 6'($urandom);
    bif.a     = $urandom;
    bif.b     = $urandom;
    lat  = 1;
    bcnt = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bif.busy) bcnt++;
      if (bif.done) begin
        got_done = 1'b1;
        break;
      end
      bif.start = poke && (lat == 5);
      @(posedge clk);
      lat++;
    end
    bif.start = 1'b0;
    if (!got_done) lat = -1;
  endtask

  int lat;
  int bcnt;
  logic [7:0] busy_pat;
  logic [7:0] done_pat;

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bif.start = 1'b0;
    bif.ctrl  = '0;
    bif.a     = '0;
    bif.b     = '0;

    vt[0]  = '{OP_ADD,  32'd5, 32'd3, 32'd8, 0, 0, 0, 0, 2};
    vt[1]  = '{OP_SUB,  32'd3, 32'd3, 32'd0, 0, 1, 0, 0, 2};
    vt[2]  = '{OP_SLT,  32'hFFFFFFFF, 32'd1, 32'd1, 0, 0, 0, 0, 2};
    vt[3]  = '{OP_SGT,  32'hFFFFFFFF, 32'd1, 32'd0, 0, 1, 0, 0, 2};
    vt[4]  = '{OP_AND,  32'hF0F0, 32'hFF00, 32'hF000, 0, 0, 0, 0, 2};
    vt[5]  = '{OP_OR,   32'hF0F0, 32'h0F00, 32'hFFF0, 0, 0, 0, 0, 2};
    vt[6]  = '{6'b111111, 32'd2, 32'd2, 32'd4, 0, 0, 0, 0, 2};
    vt[7]  = '{OP_MULU, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 32'd1,
               0, 0, 0, W + 2};
    vt[8]  = '{OP_DIVU, 32'd100, 32'd7, 32'd14, 32'd2, 0, 0, 0, W + 2};
    vt[9]  = '{OP_DIVU, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 0, 1, 0, 2};
    vt[10] = '{OP_ADD,  32'h7FFFFFFF, 32'd1, 32'h80000000, 0, 0, 0, 1, 2};
    vt[11] = '{OP_SUB,  32'h80000000, 32'd1, 32'h7FFFFFFF, 0, 0, 0, 1, 2};
    vt[12] = '{OP_ADD,  32'd1, 32'd1, 32'd2, 0, 0, 0, 0, 2};
    vt[13] = '{OP_MULU, 32'd7, 32'd9, 32'd63, 32'd0, 0, 0, 0, W + 2};
    vt[14] = '{OP_DIVU, 32'd3, 32'd10, 32'd0, 32'd3, 1, 0, 0, W + 2};
    vt[15] = '{OP_ADD,  32'hFFFFFFFF, 32'd1, 32'd0, 0, 1, 0, 0, 2};
    vt[16] = '{OP_SLT,  32'd1, 32'hFFFFFFFF, 32'd0, 0, 1, 0, 0, 2};
    vt[17] = '{OP_MULU, 32'h12345678, 32'h9ABCDEF0, 32'h242D2080,
               32'h0B00EA4E, 0, 0, 0, W + 2};

    repeat (3) @(posedge clk);
    #1;
    chk("rst.result", bif.result, 32'd0);
    chk("rst.hi", bif.hi, 32'd0);
    chk("rst.flags", {28'd0, bif.zero, bif.busy, bif.done,
        bif.div_by_zero}, 32'd0);
    chk("rst.ovf", {31'd0, bif.overflow}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      run_op(vt[i].ctrl, vt[i].a, vt[i].b, vt[i].lat > 2, lat, bcnt);
      chk($sformatf("v%0d.lat", i), 32'(lat), 32'(vt[i].lat));
      chk($sformatf("v%0d.busy", i), 32'(bcnt), 32'(vt[i].lat));
      chk($sformatf("v%0d.res", i), bif.result, vt[i].res);
      chk($sformatf("v%0d.hi", i), bif.hi, vt[i].hi);
      chk($sformatf("v%0d.zero", i), {31'd0, bif.zero}, {31'd0, vt[i].z});
      chk($sformatf("v%0d.dbz", i), {31'd0, bif.div_by_zero},
          {31'd0, vt[i].dbz});
      chk($sformatf("v%0d.ovf", i), {31'd0, bif.overflow},
          {31'd0, vt[i].ovf & OVF_EN});
      repeat (2) @(negedge clk);
      chk($sformatf("v%0d.hold", i), bif.result, vt[i].res);
      chk($sformatf("v%0d.idle", i), {30'd0, bif.busy, bif.done}, 32'd0);
    end

    // Start held high: one op every three cycles.
    @(negedge clk);
    bif.start = 1'b1;
    bif.ctrl  = OP_ADD;
    bif.a     = 32'd5;
    bif.b     = 32'd3;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      busy_pat[7-k] = bif.busy;
      done_pat[7-k] = bif.done;
    end
    bif.start = 1'b0;
    chk("held.busy", {24'd0, busy_pat}, 32'b11011011);
    chk("held.done", {24'd0, done_pat}, 32'b01001001);
    chk("held.res", bif.result, 32'd8);
    repeat (4) @(negedge clk);

    // Reset in the 5th cycle of a multiply.
    @(negedge clk);
    bif.start = 1'b1;
    bif.ctrl  = OP_MULU;
    bif.a     = 32'd7;
    bif.b     = 32'd9;
    @(posedge clk);
    #1;
    bif.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mrst.busy_pre", {31'd0, bif.busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mrst.busy", {31'd0, bif.busy}, 32'd0);
    chk("mrst.done", {31'd0, bif.done}, 32'd0);
    chk("mrst.res", bif.result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("mrst.nodone", {31'd0, bif.done}, 32'd0);
    run_op(OP_ADD, 32'd1, 32'd1, 1'b0, lat, bcnt);
    chk("mrst.lat", 32'(lat), 32'd2);
    chk("mrst.add", bif.result, 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/ula_multiciclo.md
Name: ula_multiciclo

Overview:
- Execution stage directly downstream of the ALU-control decoder; consumes its 6-bit operation code and performs the operation on two operands.
- Single-cycle ops (add, and, or, sub, slt, sgt) complete in 1 cycle.
- Iterative ops (unsigned multiply, unsigned divide) take WIDTH cycles.
- The multicycle datapath controller talks to it through a start/busy/done handshake.

Parameters:
- WIDTH, 32, operand/result width in bits (even, >= 4).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- start  input  1  request; sampled only in IDLE
- ctrl  input  6  operation code from ALU-control decoder
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- result  output  WIDTH  low result / product low half / quotient
- hi  output  WIDTH  product high half / remainder; 0 for single-cycle ops
- zero  output  1  result == 0, valid with done and held after
- busy  output  1  high from accepted start until the done cycle, inclusive
- done  output  1  one-cycle completion pulse
- div_by_zero  output  1  set with done when DIVU had b == 0
- overflow  output  1  see Optional Feature

Behaviour:
- Reset:
  - Clock is clk; reset is rst, asynchronous, active-high.
  - On reset, the FSM goes to IDLE and all outputs (result, hi, zero, busy, done, div_by_zero, overflow) are 0.
  - Reset mid-operation aborts the operation; no done is produced.
- Codes (decided, matching the decoder):
  - 000000 ADD, 000001 AND, 001000 OR, 001111 SUB.
  - 001101 SLT: signed a<b gives 1, else 0.
  - 001001 SGT: signed a>b gives 1, else 0.
  - 011000 MULU, 011010 DIVU.
  - Any other code executes as ADD.
- States: IDLE, EXEC, MUL, DIV, DONE.
- IDLE:
  - start=1 latches a, b and ctrl, and sets busy next cycle.
  - Goes to MUL for MULU, DIV for DIVU with b!=0, else EXEC.
  - DIVU with b==0 goes to EXEC as a fast path.
- EXEC:
  - Computes the single-cycle op on the latched operands; the result registers are written at the end of this cycle.
  - Then goes to DONE.
  - Total latency is start edge -> done high on the 2nd edge.
- MUL:
  - Shift-add, one bit per cycle, WIDTH cycles, driven by an internal counter counting WIDTH-1 down to 0.
  - Then goes to DONE.
  - Product is 2*WIDTH bits: {hi, result}.
- DIV:
  - Restoring division, one quotient bit per cycle, WIDTH cycles.
  - Quotient goes to result, remainder to hi.
- DIVU by zero:
  - result = all ones, hi = a, div_by_zero = 1.
  - Latency equals a single-cycle op.
- DONE:
  - done=1 and busy=1 for exactly one cycle, then IDLE.
  - result, hi, zero and div_by_zero hold until the next accepted start; they are not cleared at done.
- Iterative latency: start edge -> done high after WIDTH+2 edges.
- start while busy is ignored; no queueing.
- start in the same cycle as done is ignored; a new start is accepted only when IDLE is observed.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH.
  - SLT/SGT compare as two's complement.
  - MULU/DIVU are unsigned.
- Changes on ctrl, a or b after acceptance have no effect.

Optional Feature:
- Macro: ULA_OVERFLOW_EN.
- Enabled:
  - overflow is registered with done and held with result.
  - ADD sets it when both operands have the same sign and the result sign differs.
  - SUB sets it when the operand signs differ and the result sign differs from a.
  - overflow is 0 for all other ops.
- Disabled: the overflow port still exists but is tied 0; no overflow logic is synthesised.

Test Plan:
- Reset mid-MUL:
  - Start MULU a=7, b=9; assert rst on the 5th cycle.
  - Required: busy/done/result drop to 0 immediately; next start ADD 1+1 gives result=2.
- Single-cycle ops, WIDTH=32:
  - ADD 5+3 gives result=8, done on the 2nd edge, busy high for 2 cycles.
  - SUB 3-3 gives result=0, zero=1.
  - SLT with a=-1 (0xFFFFFFFF), b=1 gives result=1.
  - SGT with the same operands gives result=0.
  - AND 0xF0F0 & 0xFF00 gives 0xF000.
  - Unknown code 111111 with 2+2 gives result=4.
- MULU, 0xFFFFFFFF x 2:
  - Required: hi=1, result=0xFFFFFFFE.
  - done exactly WIDTH+2 edges after start; a start pulse mid-operation is ignored.
- DIVU:
  - 100/7 gives result=14, hi=2, div_by_zero=0.
  - 5/0 gives result=0xFFFFFFFF, hi=5, div_by_zero=1, with done on the 2nd edge.
- Handshake:
  - start held continuously gives back-to-back ops separated by one IDLE cycle.
  - result holds after done until the next accepted start.
- ULA_OVERFLOW_EN:
  - Enabled: ADD 0x7FFFFFFF+1 gives overflow=1; SUB 0x80000000-1 gives overflow=1; ADD 1+1 gives overflow=0.
  - Disabled: overflow is always 0 in all three cases.
